// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0] PC_INC        = 64'd4;
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~64'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} between the fetch sequencer and decode.
// Flush wins over push/pop; pop on empty and push on full are ignored.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through the gated head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// Stall- and redirect-aware PC sequencer with one outstanding imem request.
// Define FETCH_SEQ_PERF_EN to add saturating fetch/stall/kill counters.
//
// state | meaning
// IDLE  | just out of reset, request next cycle
// REQ   | issue a request at pc when buffer credit allows
// WAIT  | request in flight, response will be buffered
// DRAIN | request in flight was killed by a redirect, response dropped
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 64'h0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_kill_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] buf_count;
  logic             buf_valid;
  fetch_entry_t     buf_head, push_entry;
  logic             credit_ok, issue, resp_live, push;

  // Next state and PC; a redirect overrides whatever the state would do.
  // Only REQ issues, so nothing is in flight there and occupancy alone is the credit.
  always_comb begin
    credit_ok  = buf_count < CNT_W'(BUF_DEPTH);
    issue      = (state_q == REQ) && credit_ok;
    resp_live  = imem_rvalid && ((state_q == WAIT) || (state_q == DRAIN));
    push       = resp_live && (state_q == WAIT) && !redirect_valid;
    push_entry = '{pc: pc_q, instr: imem_rdata};
    state_d    = state_q;
    pc_d       = pc_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   if (issue) state_d = WAIT;
      WAIT:  if (imem_rvalid) begin
               state_d = REQ;
               pc_d    = pc_q + PC_INC;
             end
      DRAIN: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = pc_align(redirect_pc);
      if (resp_live)
        state_d = REQ;
      else if (issue || (state_q == WAIT) || (state_q == DRAIN))
        state_d = DRAIN;
      else
        state_d = REQ;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (id_ready),
    .flush      (redirect_valid),
    .count      (buf_count),
    .head_valid (buf_valid),
    .head       (buf_head)
  );

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign id_valid    = buf_valid;
  assign id_instr    = buf_head.instr;
  assign id_pc       = buf_head.pc;
  assign id_pc_plus4 = buf_valid ? buf_head.pc + PC_INC : '0;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_kill_q,  perf_kill_d;

  // Saturating event counters.
  always_comb begin
    perf_fetch_d = sat_inc32(perf_fetch_q, push);
    perf_stall_d = sat_inc32(perf_stall_q, (state_q == REQ) && !credit_ok);
    perf_kill_d  = sat_inc32(perf_kill_q, resp_live && !push);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_kill_q  <= perf_kill_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_kill_cnt  = perf_kill_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory/decode driver with a
// transaction-level model pushes expected deliveries; a monitor pops them.
module tb_fetch_sequencer;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;

  fetch_sequencer #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] req_log[$];
  int          n_checks = 0;
  int          n_err = 0;

  // transaction-level model of the fetch unit
  logic [63:0] model_pc;
  bit          outstanding, killed;
  logic [63:0] out_pc;
  int          wait_cnt;
  bit          pend_flush, pend_push, pend_pc_valid;
  exp_t        pend_item;
  logic [63:0] pend_pc;
  int          req_cnt;

  // stimulus knobs
  int          ready_mode;
  int          lat_min, lat_max;
  bit          stray_en, hold_resp, redir_on_resp;
  logic [63:0] redir_resp_tgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] log_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // One clock cycle: apply last cycle's effects, check request side, drive inputs.
  task automatic step(input bit do_redir, input logic [63:0] tgt);
    bit          exp_req, issued, resp_now, redir;
    logic [63:0] tgt_eff;
    @(posedge clk);
    #1;
    if (pend_flush) exp_q.delete();
    if (pend_push) exp_q.push_back(pend_item);
    if (pend_pc_valid) model_pc = pend_pc;
    pend_flush = 0; pend_push = 0; pend_pc_valid = 0;

    exp_req = !outstanding && (exp_q.size() < DEPTH);
    chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    issued = 0;
    if (imem_req) begin
      chk("imem_addr", imem_addr, model_pc);
      req_cnt++;
      req_log.push_back(imem_addr);
      outstanding = 1;
      killed      = 0;
      out_pc      = model_pc;
      wait_cnt    = int'($urandom_range(lat_max, lat_min)) - 1;
      issued      = 1;
    end

    resp_now    = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (outstanding && !issued) begin
      if (!hold_resp) begin
        if (wait_cnt == 0) begin
          resp_now    = 1;
          imem_rvalid = 1'b1;
        end else begin
          wait_cnt--;
        end
      end
    end else if (stray_en && !outstanding && !issued && ($urandom_range(3, 0) == 0)) begin
      imem_rvalid = 1'b1;
    end

    tgt_eff = tgt;
    redir   = do_redir;
    if (redir_on_resp && resp_now) begin
      redir         = 1;
      tgt_eff       = redir_resp_tgt;
      redir_on_resp = 0;
    end
    redirect_valid = redir;
    redirect_pc    = tgt_eff;
    case (ready_mode)
      0:       id_ready = 1'b1;
      1:       id_ready = 1'b0;
      default: id_ready = ($urandom_range(1, 0) == 1);
    endcase

    if (resp_now) begin
      if (!redir && !killed) begin
        pend_push       = 1;
        pend_item.pc    = out_pc;
        pend_item.instr = imem_rdata;
        pend_pc         = out_pc + 64'd4;
        pend_pc_valid   = 1;
      end
      outstanding = 0;
    end
    if (redir) begin
      pend_flush    = 1;
      pend_push     = 0;
      pend_pc       = tgt_eff & ~64'h3;
      pend_pc_valid = 1;
      if (outstanding) killed = 1;
    end
  endtask

  task automatic do_reset(input bit stray);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    id_ready       = 1'b0;
    exp_q.delete();
    outstanding = 0; killed = 0;
    pend_flush = 0; pend_push = 0; pend_pc_valid = 0;
    hold_resp = 0; redir_on_resp = 0;
    model_pc = RST_PC;
    #1;
    chk("rst imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst imem_addr", imem_addr, RST_PC);
    chk("rst id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst id_instr", {32'd0, id_instr}, 64'd0);
    chk("rst id_pc", id_pc, 64'd0);
    chk("rst id_pc_plus4", id_pc_plus4, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b1;
    imem_rvalid = stray;
    imem_rdata  = $urandom;
  endtask

  task automatic wait_issue();
    int k = 0;
    while (!outstanding && k < 20) begin
      step(0, '0);
      k++;
    end
    chk("issue timeout", {63'd0, outstanding}, 64'd1);
  endtask

  // Monitor: every cycle id_valid must reflect the model buffer; handshakes pop it.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("id_valid", {63'd0, id_valid}, {63'd0, exp_q.size() != 0});
        if (id_valid && id_ready && exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("id_instr", {32'd0, id_instr}, {32'd0, mon_e.instr});
          chk("id_pc", id_pc, mon_e.pc);
          chk("id_pc_plus4", id_pc_plus4, mon_e.pc + 64'd4);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    ready_mode = 0; lat_min = 1; lat_max = 1;
    stray_en = 0; hold_resp = 0; redir_on_resp = 0; redir_resp_tgt = '0;
    req_cnt = 0;

    // sequential fetch, 1-cycle memory, decode always ready
    do_reset(0);
    req_log.delete();
    req_cnt = 0;
    repeat (12) step(0, '0);
    chk("seq addr0", log_at(0), 64'h1000);
    chk("seq addr1", log_at(1), 64'h1004);
    chk("seq addr2", log_at(2), 64'h1008);
    chk("seq throughput", 64'(req_cnt), 64'd6);

    // decode stalled: buffer fills after two requests, then resumes
    do_reset(0);
    ready_mode = 1;
    req_cnt = 0;
    repeat (20) step(0, '0);
    chk("stall req count", 64'(req_cnt), 64'd2);
    ready_mode = 0;
    req_log.delete();
    repeat (10) step(0, '0);
    chk("resume addr", log_at(0), 64'h1008);

    // redirect while a request is in flight
    do_reset(0);
    hold_resp = 1;
    wait_issue();
    step(1, 64'h2003);
    repeat (3) step(0, '0);
    hold_resp = 0;
    req_log.delete();
    repeat (6) step(0, '0);
    chk("redirect addr", log_at(0), 64'h2000);

    // redirect coincident with the response
    lat_min = 2; lat_max = 2;
    redir_on_resp = 1;
    redir_resp_tgt = 64'h3000;
    begin
      int k = 0;
      while (redir_on_resp && k < 20) begin
        step(0, '0);
        k++;
      end
    end
    chk("coincident fired", {63'd0, redir_on_resp}, 64'd0);
    req_log.delete();
    step(0, '0);
    chk("coincident addr", log_at(0), 64'h3000);
    lat_min = 1; lat_max = 1;
    repeat (6) step(0, '0);

    // PC wrap at the top of the address space
    step(1, 64'hFFFF_FFFF_FFFF_FFFE);
    req_log.delete();
    repeat (12) step(0, '0);
    chk("wrap addr0", log_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap addr1", log_at(1), 64'h0);
    chk("wrap addr2", log_at(2), 64'h4);

    // randomized traffic
    ready_mode = 2; lat_min = 1; lat_max = 3; stray_en = 1;
    repeat (1500) step($urandom_range(11, 0) == 0, {$urandom, $urandom});

    // reset during WAIT with a stray response after release
    stray_en = 0; ready_mode = 0; lat_min = 1; lat_max = 1;
    hold_resp = 1;
    wait_issue();
    step(0, '0);
    do_reset(1);
    req_log.delete();
    repeat (8) step(0, '0);
    chk("post-reset addr", log_at(0), RST_PC);
    repeat (4) step(0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
